// File: rtl/int_ctrl_if.sv
// Bridge-side register access bus for the interrupt controller: single-cycle reads/writes.
// rdata is combinational from addr; there is no stall or backpressure on this bus.
interface int_ctrl_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/int_ctrl.sv
// Priority interrupt controller feeding CP0 HWInt[7:2]; INT_CTRL_NESTING_EN allows two-level nesting.
// irqIn edge -> PENDING next edge -> HWInt the edge after; register bus never stalls.
module int_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
    parameter int          NUM_IRQ   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irqIn,
    int_ctrl_if.slave          bus,
    output logic [NUM_IRQ-1:0] HWInt,
    input  logic               intAck,
    input  logic               eret,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] inservice_q, inservice_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] hwint_q, hwint_d;
    logic [2:0]         win_q, win_d;

    logic               sel;
    logic [1:0]         off;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ins_low;
    logic [NUM_IRQ-1:0] ins_pop;
    logic               unused_ok;

    function automatic logic [2:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = i[2:0];
        end
    endfunction

    assign sel       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign off       = bus.addr[3:2];
    assign unused_ok = ^{bus.addr[1:0], bus.wdata[31:NUM_IRQ]};

    assign eligible = pending_q & mask_q & ~inservice_q;
    assign ins_low  = inservice_q & (~inservice_q + 1'b1);
    assign ins_pop  = inservice_q & ~ins_low;

    assign w1c    = (bus.we && sel && off == 2'd0) ? bus.wdata[NUM_IRQ-1:0] : '0;
    assign mask_d = (bus.we && sel && off == 2'd1) ? bus.wdata[NUM_IRQ-1:0] : mask_q;
    assign mode_d = (bus.we && sel && off == 2'd2) ? bus.wdata[NUM_IRQ-1:0] : mode_q;

    // Edge bits: a new edge beats any clear in the same cycle. Level bits track irqIn.
    assign pending_d = (mode_q & ((pending_q & ~w1c & ~ack_clr) | (irqIn & ~irq_prev_q)))
                     | (~mode_q & irqIn);

`ifdef INT_CTRL_NESTING_EN
    logic [NUM_IRQ-1:0] nest_cand;
    logic               one_level;
    assign nest_cand = eligible & (ins_low - 1'b1);
    assign one_level = ((inservice_q & (inservice_q - 1'b1)) == '0);
`endif

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        hwint_d     = hwint_q;
        inservice_d = inservice_q;
        ack_clr     = '0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    win_d   = lowest_idx(eligible);
                    hwint_d = NUM_IRQ'(1) << lowest_idx(eligible);
                    state_d = REQ;
                end
            end
            REQ: begin
                // An outer handler's eret (nested case only) retires it and drops this request.
                if (eret && |inservice_q) begin
                    inservice_d = ins_pop;
                    hwint_d     = '0;
                    state_d     = (|ins_pop) ? SERVICE : IDLE;
                end else if (intAck) begin
                    inservice_d[win_q] = 1'b1;
                    ack_clr[win_q]     = 1'b1;
                    hwint_d            = '0;
                    state_d            = SERVICE;
                end else if (!eligible[win_q]) begin
                    hwint_d = '0;
                    state_d = (|inservice_q) ? SERVICE : IDLE;
                end
            end
            SERVICE: begin
                hwint_d = '0;
                if (eret) begin
                    inservice_d = ins_pop;
                    if (ins_pop == '0) state_d = IDLE;
                end
`ifdef INT_CTRL_NESTING_EN
                else if (|nest_cand && one_level) begin
                    win_d   = lowest_idx(nest_cand);
                    hwint_d = NUM_IRQ'(1) << lowest_idx(nest_cand);
                    state_d = REQ;
                end
`endif
            end
            default: begin
                hwint_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            mask_q      <= '0;
            mode_q      <= '0;
            inservice_q <= '0;
            irq_prev_q  <= '0;
            hwint_q     <= '0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            inservice_q <= inservice_d;
            irq_prev_q  <= irqIn;
            hwint_q     <= hwint_d;
            win_q       <= win_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (sel) begin
            case (off)
                2'd0:    bus.rdata = {26'b0, pending_q};
                2'd1:    bus.rdata = {26'b0, mask_q};
                2'd2:    bus.rdata = {26'b0, mode_q};
                default: bus.rdata = {18'b0, state_q, 1'b0, win_q, 2'b0, inservice_q};
            endcase
        end
    end

    assign HWInt = hwint_q;
    assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl; expected values are hand-derived per step.
module tb_int_ctrl;
    localparam logic [31:0] BASE = 32'h0000_7F20;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] irqIn;
    logic [5:0] HWInt;
    logic       intAck;
    logic       eret;
    logic       busy;
    int         checks = 0;
    int         errors = 0;

    int_ctrl_if bus();

    int_ctrl #(.BASE_ADDR(BASE), .NUM_IRQ(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .irqIn  (irqIn),
        .bus    (bus),
        .HWInt  (HWInt),
        .intAck (intAck),
        .eret   (eret),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        bus.addr  = BASE + 32'(off);
        bus.wdata = d;
        bus.we    = 1'b1;
        step();
        bus.we    = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [3:0] off, input logic [31:0] exp);
        bus.addr = BASE + 32'(off);
        #1;
        check(tag, bus.rdata, exp);
    endtask

    initial begin
        reset = 1'b1; irqIn = '0; intAck = 1'b0; eret = 1'b0;
        bus.addr = BASE; bus.we = 1'b0; bus.wdata = '0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        chk_rd("rst_status", 4'hC, 32'h0);
        chk_rd("rst_mask", 4'h4, 32'h0);
        check("rst_hwint", 32'(HWInt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Edge-mode pulse on line 0
        wr(4'h4, 32'h3F);
        wr(4'h8, 32'h01);
        irqIn = 6'b000001; step();
        irqIn = 6'b000000;
        check("edge_latency", 32'(HWInt), 32'h0);
        step();
        check("edge_hwint", 32'(HWInt), 32'h01);
        check("edge_busy", 32'(busy), 32'h1);
        chk_rd("edge_pending", 4'h0, 32'h01);
        chk_rd("edge_status_req", 4'hC, 32'h0000_1000);
        intAck = 1'b1; step(); intAck = 1'b0;
        check("ack_hwint", 32'(HWInt), 32'h0);
        chk_rd("ack_status", 4'hC, 32'h0000_2001);
        chk_rd("ack_pending", 4'h0, 32'h0);
        eret = 1'b1; step(); eret = 1'b0;
        chk_rd("eret_status", 4'hC, 32'h0);
        check("eret_busy", 32'(busy), 32'h0);

        // Level mode, two lines together
        wr(4'h8, 32'h00);
        irqIn = 6'b100100; step(); step();
        check("lvl_win2", 32'(HWInt), 32'h04);
        intAck = 1'b1; step(); intAck = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
        step();
        check("lvl_rewin2", 32'(HWInt), 32'h04);
        chk_rd("lvl_status", 4'hC, 32'h0000_1200);
        intAck = 1'b1; step(); intAck = 1'b0;
        irqIn = 6'b100000;
        eret = 1'b1; step(); eret = 1'b0;
        step();
        check("lvl_win5", 32'(HWInt), 32'h20);
        intAck = 1'b1; step(); intAck = 1'b0;
        irqIn = 6'b000000;
        eret = 1'b1; step(); eret = 1'b0;
        step();

        // Mask withdrawn while in REQ
        irqIn = 6'b001000; step(); step();
        check("mask_req_hwint", 32'(HWInt), 32'h08);
        wr(4'h4, 32'h00);
        step();
        check("mask_drop_hwint", 32'(HWInt), 32'h0);
        chk_rd("mask_drop_status", 4'hC, 32'h0000_0300);
        irqIn = 6'b000000;

        // W1C versus a simultaneous new edge
        wr(4'h8, 32'h02);
        irqIn = 6'b000010; step();
        irqIn = 6'b000000; step();
        chk_rd("w1c_pend_set", 4'h0, 32'h02);
        wr(4'h0, 32'h02);
        chk_rd("w1c_clear", 4'h0, 32'h0);
        irqIn = 6'b000010; step();
        irqIn = 6'b000000; step();
        irqIn = 6'b000010;
        wr(4'h0, 32'h02);
        irqIn = 6'b000000;
        chk_rd("w1c_set_wins", 4'h0, 32'h02);
        wr(4'h0, 32'h02);

        // Higher-priority edge arriving while line 4 is in service
        wr(4'h8, 32'h12);
        wr(4'h4, 32'h3F);
        irqIn = 6'b010000; step();
        irqIn = 6'b000000; step();
        check("nest_first_hwint", 32'(HWInt), 32'h10);
        intAck = 1'b1; step(); intAck = 1'b0;
        irqIn = 6'b000010; step();
        irqIn = 6'b000000; step();
`ifdef INT_CTRL_NESTING_EN
        check("nest_hwint", 32'(HWInt), 32'h02);
        intAck = 1'b1; step(); intAck = 1'b0;
        chk_rd("nest_status2", 4'hC, 32'h0000_2112);
        eret = 1'b1; step(); eret = 1'b0;
        chk_rd("nest_pop1", 4'hC, 32'h0000_2110);
        eret = 1'b1; step(); eret = 1'b0;
        chk_rd("nest_pop2", 4'hC, 32'h0000_0100);
`else
        check("nonest_hwint", 32'(HWInt), 32'h0);
        step();
        check("nonest_hold", 32'(HWInt), 32'h0);
        chk_rd("nonest_status", 4'hC, 32'h0000_2410);
        eret = 1'b1; step(); eret = 1'b0;
        step();
        check("nonest_after_eret", 32'(HWInt), 32'h02);
        intAck = 1'b1; step(); intAck = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
        chk_rd("nonest_done", 4'hC, 32'h0000_0100);
`endif

        // Reset while in SERVICE
        irqIn = 6'b000001; step(); step();
        intAck = 1'b1; step(); intAck = 1'b0;
        check("svc_busy", 32'(busy), 32'h1);
        reset = 1'b1; step(); reset = 1'b0;
        check("rst2_hwint", 32'(HWInt), 32'h0);
        check("rst2_busy", 32'(busy), 32'h0);
        chk_rd("rst2_status", 4'hC, 32'h0);
        chk_rd("rst2_pending", 4'h0, 32'h0);
        chk_rd("rst2_mode", 4'h8, 32'h0);
        irqIn = 6'b000000;

        // Address outside the block and STATUS write ignored
        chk_rd("out_of_block", 4'h0 + 4'h0, 32'h0);
        bus.addr = BASE + 32'h10;
        #1;
        check("out_of_block_rd", bus.rdata, 32'h0);
        wr(4'hC, 32'hFFFF_FFFF);
        chk_rd("status_wr_ignored", 4'hC, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
